rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 24 ++
 rtl/rr_arb4.sv | 81 ++++++++
 tb/tb_rr_arb4.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state type for the round-robin arbiter
//   N_REQ   number of requesters
//   HOLD_W  width of the hold counter (enough for MAX_HOLD up to 15)
//   state_t arbiter state, IDLE (no grant) or BUSY (one owner)
package arb_pkg;
    localparam int N_REQ  = 4;
    localparam int HOLD_W = 4;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr
//   req       [3:0] request vector, bit i is requester i
//   ptr       [1:0] first index searched, then ptr+1, ptr+2, ptr+3 (mod 4)
//   found           1 when any request is set
//   winner_id [1:0] first set request in search order, 0 when none
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             found,
    output logic [1:0]       winner_id
);
    logic [N_REQ-1:0] rot;
    logic [1:0]       off;
    // rot[k] is req[ptr+k], so a fixed priority encoder on rot gives the offset
    assign rot = ptr == 2'd0 ? req :
                 ptr == 2'd1 ? {req[0], req[3:1]} :
                 ptr == 2'd2 ? {req[1:0], req[3:2]} :
                               {req[2:0], req[3]};
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign found = |req;
    assign winner_id = found ? ptr + off : 2'd0;
endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter with hold-time preemption
//   clk       single clock
//   reset     synchronous active-high reset
//   req  [3:0] request per requester
//   grant[3:0] registered one-hot-or-zero grant
//   grant_id  registered owner index, 0 when idle
//   busy      1 whenever grant is non-zero
//   preempt   one-cycle pulse in the first cycle after a timeout handoff
module rr_arb4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       grant_id,
    output logic             busy,
    output logic             preempt
);
    state_t            state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              owner_req;
    logic              others;
    logic              at_max;
    logic              timeout;
    logic              keep;
    logic              found;
    logic [1:0]        pick_ptr;
    logic [1:0]        winner_id;

    assign owner_req = req[grant_id];
    assign others    = |(req & ~grant);
    assign at_max    = hold_cnt == HOLD_W'(MAX_HOLD);
    assign timeout   = state == BUSY && owner_req && others && at_max;
    assign keep      = state == BUSY && owner_req && !timeout;
    // on a handoff the search starts after the owner, which leaves the owner last
    assign pick_ptr  = state == BUSY ? grant_id + 2'd1 : ptr;

    rr_pick u_pick (
        .req       (req),
        .ptr       (pick_ptr),
        .found     (found),
        .winner_id (winner_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            preempt <= timeout;
            if (keep) begin
                hold_cnt <= at_max ? hold_cnt : hold_cnt + HOLD_W'(1);
            end else begin
                if (state == BUSY)
                    ptr <= grant_id + 2'd1;
                if (found) begin
                    state    <= BUSY;
                    grant    <= N_REQ'(1) << winner_id;
                    grant_id <= winner_id;
                    busy     <= 1'b1;
                    hold_cnt <= HOLD_W'(1);
                end else begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed and random checks of rr_arb4 against an integer reference model
module tb_rr_arb4;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_pre   = 0;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model(input logic [3:0] r, input logic rst);
        int w;
        logic [3:0] rest;
        m_pre = 0;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_hold  = 1;
            end
        end else begin
            rest = r;
            rest[m_owner] = 1'b0;
            if (r[m_owner] && !(m_hold == MAX_HOLD && rest != 0)) begin
                m_hold = m_hold < MAX_HOLD ? m_hold + 1 : MAX_HOLD;
            end else begin
                m_pre = r[m_owner] ? 1 : 0;
                m_ptr = (m_owner + 1) % 4;
                w = pick(r, m_ptr);
                m_owner = w;
                m_hold  = w >= 0 ? 1 : 0;
            end
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rst);
        logic [3:0] eg;
        req   = r;
        reset = rst;
        model(r, rst);
        @(posedge clk);
        #1;
        eg = m_owner < 0 ? 4'b0 : 4'(1 << m_owner);
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_id", 32'(grant_id), m_owner < 0 ? 0 : m_owner);
        chk("busy", 32'(busy), m_owner >= 0 ? 1 : 0);
        chk("preempt", 32'(preempt), m_pre);
        chk("ptr", 32'(dut.ptr), m_ptr);
        chk("hold_cnt", 32'(dut.hold_cnt), m_hold);
        chk("onehot0", 32'($onehot0(grant)), 1);
        chk("busy_vs_grant", 32'(busy), 32'(|grant));
    endtask

    initial begin
        cyc(4'b0000, 1'b1);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ptr", 32'(dut.ptr), 0);

        cyc(4'b0001, 1'b0);
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_id", 32'(grant_id), 0);
        chk("single_busy", 32'(busy), 1);
        cyc(4'b0000, 1'b0);
        chk("release_grant", 32'(grant), 0);
        chk("release_busy", 32'(busy), 0);
        chk("release_ptr", 32'(dut.ptr), 1);

        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1111, 1'b0);
            chk("rr_grant", 32'(grant), 32'(1 << ((i / 4) % 4)));
            chk("rr_preempt", 32'(preempt), (i % 4 == 0 && i > 0) ? 1 : 0);
        end

        cyc(4'b0000, 1'b1);
        cyc(4'b0010, 1'b0);
        chk("ho_owner", 32'(grant), 32'h2);
        cyc(4'b0110, 1'b0);
        chk("ho_hold", 32'(grant), 32'h2);
        cyc(4'b0100, 1'b0);
        chk("ho_grant", 32'(grant), 32'h4);
        chk("ho_preempt", 32'(preempt), 0);

        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0001, 1'b0);
            chk("solo_grant", 32'(grant), 32'h1);
            chk("solo_preempt", 32'(preempt), 0);
            chk("solo_hold", 32'(dut.hold_cnt), i + 1 < MAX_HOLD ? i + 1 : MAX_HOLD);
        end

        cyc(4'b0000, 1'b1);
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        chk("mid_owner", 32'(grant), 32'h4);
        cyc(4'b0100, 1'b1);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_ptr", 32'(dut.ptr), 0);
        cyc(4'b1100, 1'b0);
        chk("mid_after", 32'(grant), 32'h4);

        cyc(4'b0000, 1'b1);
        for (int i = 0; i < 32; i++)
            cyc(4'($urandom_range(0, 15)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
